// File: rtl/jtpopeye_pkg.sv
// jtpopeye_pkg: shared definitions for the Popeye video colour mixer.
//   - Layer-select encoding carried down the colour-mixer pipeline.
//   - Pipeline latency (in pxl_cen ticks) of the colour mixer.
//   - RGB 3-3-2 field widths and the palette byte decode helper.
//   - Object transparency mask: an object pixel is transparent when
//     its two low colour bits are both zero.
package jtpopeye_pkg;

  localparam int COLMIX_LAT = 3;

  localparam int RED_W   = 3;
  localparam int GREEN_W = 3;
  localparam int BLUE_W  = 2;

  localparam logic [1:0] OBJ_TRANSP_MASK = 2'b11;

  // NOLAYER only occurs when layer masking disables every candidate layer.
  typedef enum logic [1:0] {
    BAK     = 2'd0,
    OBJ     = 2'd1,
    TXT     = 2'd2,
    NOLAYER = 2'd3
  } layer_e;

  typedef struct packed {
    logic [BLUE_W-1:0]  b;
    logic [GREEN_W-1:0] g;
    logic [RED_W-1:0]   r;
  } rgb_t;

  function automatic logic obj_opaque(input logic [7:0] objc);
    return |(objc[1:0] & OBJ_TRANSP_MASK);
  endfunction

  // PROM byte layout: bbgggrrr
  function automatic rgb_t pal_decode(input logic [7:0] q);
    rgb_t v;
    v.r = q[2:0];
    v.g = q[5:3];
    v.b = q[7:6];
    return v;
  endfunction

endpackage

// File: rtl/jtgng_prom.sv
// jtgng_prom: single-clock PROM image with a programming write port and a
// registered, clock-enabled read port.
// Parameters: dw data width, aw address width, simfile image name.
// Ports:
//   i_clk      clock
//   i_rst_n    async active-low reset of the read register (not the array)
//   i_cen      read enable; the read register only updates on it
//   i_data     programming data
//   i_rd_addr  read address
//   i_wr_addr  programming address
//   i_we       programming strobe, honoured on any clock edge
//   o_q        registered read data (old data on same-address write)
module jtgng_prom #(
  parameter int    dw      = 8,
  parameter int    aw      = 10,
  parameter string simfile = ""
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cen,
  input  logic [dw-1:0] i_data,
  input  logic [aw-1:0] i_rd_addr,
  input  logic [aw-1:0] i_wr_addr,
  input  logic          i_we,
  output logic [dw-1:0] o_q
);

  logic [dw-1:0] r_mem [0:(2**aw)-1];
  logic [dw-1:0] r_q;

  // The image is always delivered through the programming port; a named
  // image file is only a hint for simulation wrappers that preload it.
  if (simfile != "") begin : g_simfile_hint
  end

  // Programming port, independent of the pixel enable
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_data;
    end
  end

  // Registered read; a concurrent write to the same address is seen next read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= {dw{1'b0}};
    end else if (i_cen) begin
      r_q <= r_mem[i_rd_addr];
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/jtpopeye_blank_dly.sv
// jtpopeye_blank_dly: DEPTH-stage delay line for LHBL/LVBL advancing on the
// pixel enable, asynchronously cleared to 0.
// Parameter: DEPTH number of stages (at least 2).
// Ports:
//   i_clk, i_rst_n, i_cen       clock, async reset, pixel enable
//   i_lhbl, i_lvbl              blank flags entering the pipeline
//   o_lhbl_pre, o_lvbl_pre      flags after DEPTH-1 stages
//   o_lhbl, o_lvbl              flags after DEPTH stages
module jtpopeye_blank_dly #(
  parameter int DEPTH = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_cen,
  input  logic i_lhbl,
  input  logic i_lvbl,
  output logic o_lhbl_pre,
  output logic o_lvbl_pre,
  output logic o_lhbl,
  output logic o_lvbl
);

  logic [DEPTH-1:0] r_lhbl_sr;
  logic [DEPTH-1:0] r_lvbl_sr;

  // Shift both flags one stage per pixel enable
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lhbl_sr <= {DEPTH{1'b0}};
      r_lvbl_sr <= {DEPTH{1'b0}};
    end else if (i_cen) begin
      r_lhbl_sr <= {r_lhbl_sr[DEPTH-2:0], i_lhbl};
      r_lvbl_sr <= {r_lvbl_sr[DEPTH-2:0], i_lvbl};
    end
  end

  assign o_lhbl_pre = r_lhbl_sr[DEPTH-2];
  assign o_lvbl_pre = r_lvbl_sr[DEPTH-2];
  assign o_lhbl     = r_lhbl_sr[DEPTH-1];
  assign o_lvbl     = r_lvbl_sr[DEPTH-1];

endmodule

// File: rtl/jtpopeye_colmix.sv
// jtpopeye_colmix: final video stage. Merges text, object and background
// by fixed priority (text > object > background), looks the colour up in
// the palette PROMs and outputs blanked 3-3-2 RGB with delayed blank flags.
// Three pipeline stages, each advancing only on pxl_cen:
//   A: PROM addresses, layer select, blanks
//   B: PROM read data, layer select, blanks
//   C: RGB (blanked), LHBL_dly/LVBL_dly
// Optional feature macro: JTPOPEYE_LAYER_MASK_EN adds gfx_en[2:0]
//   (bit0 text, bit1 object, bit2 background); a cleared bit makes that
//   layer transparent.
// Ports:
//   clk, rst_n, pxl_cen          clock, async active-low reset, pixel enable
//   LHBL, LVBL                   blanking inputs, active low
//   TXTV, TXTC                   text opaque flag and colour index
//   OBJC                         object colour (transparent when [1:0]==0)
//   BAKC                         background colour index
//   prog_addr, prom_din          PROM programming address/data
//   prom_pal_we, prom_obj_we     programming strobes (32 / 256 entries)
//   red, green, blue             colour output
//   LHBL_dly, LVBL_dly           blank flags aligned to the colour output
module jtpopeye_colmix
  import jtpopeye_pkg::*;
#(
  parameter string PAL_SIM = "",
  parameter string OBJ_SIM = ""
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pxl_cen,
  input  logic         LHBL,
  input  logic         LVBL,
  input  logic         TXTV,
  input  logic [3:0]   TXTC,
  input  logic [7:0]   OBJC,
  input  logic [3:0]   BAKC,
  input  logic [7:0]   prog_addr,
  input  logic [7:0]   prom_din,
  input  logic         prom_pal_we,
  input  logic         prom_obj_we,
`ifdef JTPOPEYE_LAYER_MASK_EN
  input  logic [2:0]   gfx_en,
`endif
  output logic [RED_W-1:0]   red,
  output logic [GREEN_W-1:0] green,
  output logic [BLUE_W-1:0]  blue,
  output logic         LHBL_dly,
  output logic         LVBL_dly
);

  logic [2:0] w_en;
  layer_e     w_sel;
  logic [4:0] w_pal_addr;

  layer_e     r_sel_a;
  logic [4:0] r_pal_addr;
  logic [7:0] r_obj_addr;
  layer_e     r_sel_b;

  logic [7:0] w_pal_q;
  logic [7:0] w_obj_q;
  logic [7:0] w_q;
  logic       w_lhbl_b;
  logic       w_lvbl_b;
  rgb_t       w_rgb;
  rgb_t       r_rgb;

`ifdef JTPOPEYE_LAYER_MASK_EN
  assign w_en = gfx_en;
`else
  assign w_en = 3'b111;
`endif

  // Layer priority and palette address for the current input pixel
  always_comb begin
    w_sel      = NOLAYER;
    w_pal_addr = {1'b0, BAKC};
    if (w_en[0] && TXTV) begin
      w_sel      = TXT;
      w_pal_addr = {1'b1, TXTC};
    end else if (w_en[1] && obj_opaque(OBJC)) begin
      w_sel = OBJ;
    end else if (w_en[2]) begin
      w_sel = BAK;
    end else begin
      w_sel = NOLAYER;
    end
  end

  // Stage A: PROM addresses and layer select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_a    <= BAK;
      r_pal_addr <= 5'd0;
      r_obj_addr <= 8'd0;
    end else if (pxl_cen) begin
      r_sel_a    <= w_sel;
      r_pal_addr <= w_pal_addr;
      r_obj_addr <= OBJC;
    end
  end

  // Stage B: layer select follows the PROM read registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_b <= BAK;
    end else if (pxl_cen) begin
      r_sel_b <= r_sel_a;
    end
  end

  jtgng_prom #(.dw(8), .aw(5), .simfile(PAL_SIM)) u_pal_prom (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_cen     (pxl_cen),
    .i_data    (prom_din),
    .i_rd_addr (r_pal_addr),
    .i_wr_addr (prog_addr[4:0]),
    .i_we      (prom_pal_we),
    .o_q       (w_pal_q)
  );

  jtgng_prom #(.dw(8), .aw(8), .simfile(OBJ_SIM)) u_obj_prom (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_cen     (pxl_cen),
    .i_data    (prom_din),
    .i_rd_addr (r_obj_addr),
    .i_wr_addr (prog_addr),
    .i_we      (prom_obj_we),
    .o_q       (w_obj_q)
  );

  // Blank flags: stage-B taps gate the colour, final taps are the outputs
  jtpopeye_blank_dly #(.DEPTH(COLMIX_LAT)) u_blank_dly (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_cen      (pxl_cen),
    .i_lhbl     (LHBL),
    .i_lvbl     (LVBL),
    .o_lhbl_pre (w_lhbl_b),
    .o_lvbl_pre (w_lvbl_b),
    .o_lhbl     (LHBL_dly),
    .o_lvbl     (LVBL_dly)
  );

  // Pick the PROM byte for the selected layer and apply blanking
  always_comb begin
    w_q = 8'h00;
    case (r_sel_b)
      TXT:     w_q = w_pal_q;
      BAK:     w_q = w_pal_q;
      OBJ:     w_q = w_obj_q;
      default: w_q = 8'h00;
    endcase
    if (w_lhbl_b && w_lvbl_b) begin
      w_rgb = pal_decode(w_q);
    end else begin
      w_rgb = pal_decode(8'h00);
    end
  end

  // Stage C: registered colour output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= pal_decode(8'h00);
    end else if (pxl_cen) begin
      r_rgb <= w_rgb;
    end
  end

  assign red   = r_rgb.r;
  assign green = r_rgb.g;
  assign blue  = r_rgb.b;

endmodule
